// File: rtl/uart_rx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_rx_pkg
//  Description : Shared definitions for the UART receiver with FIFO:
//                receiver FSM state encoding and the minimum bit divider.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_rx_pkg;

    // Smallest accepted clocks-per-bit; smaller programmed values are raised
    // to this so the half-period start-bit wait is never zero.
    localparam int MIN_DIVIDER = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_mem
//  Description : Synchronous FIFO, power-of-two depth, registered status.
//                A push while full is accepted only if a pop happens in the
//                same cycle; a pop while empty is ignored.
//  Ports       : clk, i_rst_n (async, active-low)
//                i_push/i_wdata  write side
//                i_pop/o_rdata   read side (o_rdata = head entry)
//                o_full, o_empty, o_valid (= not empty), o_level
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             r_valid;
    logic             r_full;

    logic             w_do_pop;
    logic             w_do_push;
    logic [LW-1:0]    w_level_next;

    assign w_do_pop  = i_pop && r_valid;
    // When full, the slot freed by a simultaneous pop makes room for the push.
    assign w_do_push = i_push && (!r_full || w_do_pop);

    always_comb begin
        w_level_next = r_level;
        if (w_do_push && !w_do_pop) begin
            w_level_next = r_level + LW'(1);
        end else if (w_do_pop && !w_do_push) begin
            w_level_next = r_level - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_valid <= 1'b0;
            r_full  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + AW'(1);   // wraps modulo DEPTH
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_level <= w_level_next;
            r_valid <= (w_level_next != '0);
            r_full  <= (w_level_next == LW'(DEPTH));
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_valid = r_valid;
    assign o_empty = !r_valid;
    assign o_level = r_level;

endmodule : uart_rx_fifo_mem
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : UART receiver (start/data/optional parity/stop) feeding a
//                small receive FIFO, with sticky frame/parity/overrun flags.
//  Build macro : UART_RX_PARITY_EN - compiles in the PARITY state and parity
//                checking; without it the parity cfg inputs are ignored and
//                parity_err is constant 0.
//  Ports       : clk, resetn (async, active-low)
//                ser_rx          serial line, idle high, asynchronous
//                cfg_divider     clocks per bit (raised to MIN_DIVIDER)
//                cfg_parity_en   parity bit follows data
//                cfg_parity_odd  1 = odd, 0 = even parity
//                rd_valid/rd_ready/rd_data  FIFO read handshake
//                fifo_level      occupied entries
//                frame_err, parity_err, overrun  sticky flags, err_clr clears
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          ser_rx,
    input  logic [DIV_WIDTH-1:0]          cfg_divider,
    input  logic                          cfg_parity_en,
    input  logic                          cfg_parity_odd,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    input  logic                          err_clr
);

    localparam int BCW = $clog2(DATA_BITS + 1);

    // ------------------------------------------------------------------
    // Input synchronizer (idles high so reset does not look like a start)
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= ser_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    rx_state_t             r_state;
    rx_state_t             w_state_next;
    logic [DIV_WIDTH-1:0]  r_div;
    logic [DIV_WIDTH-1:0]  r_cnt;
    logic [BCW-1:0]        r_bitcnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_push;
    // Requires the line to be seen high in IDLE before a new start is
    // accepted, so a low line after reset or after a bad stop bit is not
    // mistaken for a start bit.
    logic                  r_armed;

    logic                  w_tick;
    logic                  w_start;
    logic                  w_frame_evt;
    logic                  w_par_evt;
    logic                  w_push_next;
    logic                  w_par_bad;
    logic [DIV_WIDTH-1:0]  w_div_lat;

    assign w_tick    = (r_cnt == '0);
    assign w_div_lat = (cfg_divider < DIV_WIDTH'(MIN_DIVIDER)) ?
                       DIV_WIDTH'(MIN_DIVIDER) : cfg_divider;

`ifdef UART_RX_PARITY_EN
    logic r_par_en;
    logic r_par_odd;
    logic r_par_bad;
    logic r_parity_err;

    assign w_par_bad = r_par_bad;

    // Parity mode is captured at start detection so mid-frame cfg changes
    // cannot alter the frame being received.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_par_bad <= 1'b0;
        end else if (w_start) begin
            r_par_en  <= cfg_parity_en;
            r_par_odd <= cfg_parity_odd;
            r_par_bad <= 1'b0;
        end else if (r_state == PARITY && w_tick) begin
            // Even: data ^ parity bit must be 0; odd: must be 1.
            r_par_bad <= (^r_shift) ^ r_rx_sync ^ r_par_odd;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_par_evt | (r_parity_err & ~err_clr);
        end
    end

    assign parity_err = r_parity_err;
`else
    logic w_unused_parity_cfg;
    assign w_unused_parity_cfg = cfg_parity_en ^ cfg_parity_odd;
    assign w_par_bad  = 1'b0;
    assign parity_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register + next-state/event decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_frame_evt  = 1'b0;
        w_par_evt    = 1'b0;
        w_push_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_armed && !r_rx_sync) begin
                    w_start      = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_next = r_rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_tick && (r_bitcnt == BCW'(DATA_BITS - 1))) begin
`ifdef UART_RX_PARITY_EN
                    w_state_next = r_par_en ? PARITY : STOP;
`else
                    w_state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    w_state_next = IDLE;
                    w_frame_evt  = !r_rx_sync;
                    w_par_evt    = w_par_bad;
                    w_push_next  = r_rx_sync && !w_par_bad;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bit timing and data path
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_div    <= '0;
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_push   <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_push <= w_push_next;
            if (r_state == IDLE) begin
                if (w_start) begin
                    r_div   <= w_div_lat;
                    // Counter reaches zero 'half' cycles after loading.
                    r_cnt   <= (w_div_lat >> 1) - DIV_WIDTH'(1);
                    r_armed <= 1'b0;
                end else if (r_rx_sync) begin
                    r_armed <= 1'b1;
                end
            end else begin
                r_cnt <= w_tick ? (r_div - DIV_WIDTH'(1)) : (r_cnt - DIV_WIDTH'(1));
                if (w_tick && r_state == START) begin
                    r_bitcnt <= '0;
                end
                if (w_tick && r_state == DATA) begin
                    r_shift  <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
                    r_bitcnt <= r_bitcnt + BCW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_overrun_evt;

    assign w_pop         = rd_valid && rd_ready;
    assign w_overrun_evt = r_push && w_full && !w_pop;

    uart_rx_fifo_mem #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_rst_n (resetn),
        .i_push  (r_push),
        .i_wdata (r_shift),
        .i_pop   (w_pop),
        .o_rdata (rd_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_valid (rd_valid),
        .o_level (fifo_level)
    );

    logic w_unused_empty;
    assign w_unused_empty = w_empty;

    // ------------------------------------------------------------------
    // Sticky flags: a new event wins over a same-cycle clear
    // ------------------------------------------------------------------
    logic r_frame_err;
    logic r_overrun;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_evt   | (r_frame_err & ~err_clr);
            r_overrun   <= w_overrun_evt | (r_overrun   & ~err_clr);
        end
    end

    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo. Expected bytes are
//                queued when a good frame is driven and compared on pop.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;
    import uart_rx_pkg::*;

    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic          clk         = 1'b0;
    logic          resetn      = 1'b0;
    logic          ser_rx      = 1'b1;
    logic [DW-1:0] cfg_divider = 32'd106;
    logic          cfg_par_en  = 1'b0;
    logic          cfg_par_odd = 1'b0;
    logic          rd_ready    = 1'b0;
    logic          err_clr     = 1'b0;
    logic          rd_valid;
    logic [DB-1:0] rd_data;
    logic [2:0]    fifo_level;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;

    uart_rx_fifo #(
        .DATA_BITS  (DB),
        .FIFO_DEPTH (DEPTH),
        .DIV_WIDTH  (DW)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ser_rx         (ser_rx),
        .cfg_divider    (cfg_divider),
        .cfg_parity_en  (cfg_par_en),
        .cfg_parity_odd (cfg_par_odd),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_data        (rd_data),
        .fifo_level     (fifo_level),
        .frame_err      (frame_err),
        .parity_err     (parity_err),
        .overrun        (overrun),
        .err_clr        (err_clr)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DB-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one frame starting at a negedge; a low stop bit is held for 60%
    // of a period, then the line idles high for two periods.
    task automatic send_frame(input logic [8:0] data, input int div,
                              input bit with_par, input bit par_bit, input bit stop_val);
        ser_rx = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            ser_rx = data[i];
            repeat (div) @(negedge clk);
        end
        if (with_par) begin
            ser_rx = par_bit;
            repeat (div) @(negedge clk);
        end
        ser_rx = stop_val;
        if (stop_val) repeat (div) @(negedge clk);
        else          repeat (div * 6 / 10) @(negedge clk);
        ser_rx = 1'b1;
        repeat (div * 2) @(negedge clk);
    endtask

    task automatic pop_check(input string tag);
        logic [DB-1:0] exp;
        if (exp_q.size() == 0) begin
            check_eq({tag, " valid"}, 32'(rd_valid), 32'd0);
            return;
        end
        exp = exp_q.pop_front();
        check_eq({tag, " valid"}, 32'(rd_valid), 32'd1);
        check_eq({tag, " data"}, 32'(rd_data), 32'(exp));
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        // ---------------- reset state
        check_eq("rst rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst level", 32'(fifo_level), 32'd0);
        check_eq("rst rd_data", 32'(rd_data), 32'd0);
        check_eq("rst flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // ---------------- 0x41 at 8N1, divider 106, latency bound
        fork
            send_frame(9'h041, 106, 1'b0, 1'b0, 1'b1);
            begin
                int n = 0;
                while (!rd_valid && n < 1100) begin
                    @(negedge clk);
                    n++;
                end
                check_eq("latency<=1012", 32'(rd_valid && n <= 1012), 32'd1);
            end
        join
        exp_q.push_back(8'h41);
        check_eq("41 level", 32'(fifo_level), 32'd1);
        check_eq("41 flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
        pop_check("41 pop");
        check_eq("41 drained", 32'(fifo_level), 32'd0);

        // ---------------- 40-cycle glitch
        ser_rx = 1'b0;
        repeat (40) @(negedge clk);
        ser_rx = 1'b1;
        repeat (300) @(negedge clk);
        check_eq("glitch level", 32'(fifo_level), 32'd0);
        check_eq("glitch state", 32'(dut.r_state), 32'(IDLE));
        check_eq("glitch flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);

        // ---------------- low stop bit on 0x55
        send_frame(9'h055, 106, 1'b0, 1'b0, 1'b0);
        check_eq("ferr level", 32'(fifo_level), 32'd0);
        check_eq("ferr set", 32'(frame_err), 32'd1);
        pulse_clr();
        check_eq("ferr cleared", 32'(frame_err), 32'd0);
        // clear pulse coinciding with the stop sample must not win
        fork
            send_frame(9'h055, 106, 1'b0, 1'b0, 1'b0);
            begin
                int n = 0;
                while (!(dut.r_state == STOP && dut.r_cnt == '0) && n < 1500) begin
                    @(negedge clk);
                    n++;
                end
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
            end
        join
        check_eq("ferr vs clr", 32'(frame_err), 32'd1);
        pulse_clr();

        // ---------------- divider below minimum (2 -> 4)
        cfg_divider = 32'd2;
        send_frame(9'h09C, 4, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(8'h9C);
        pop_check("mindiv");

        // ---------------- cfg changes mid-frame ignored
        cfg_divider = 32'd16;
        fork
            send_frame(9'h0C3, 16, 1'b0, 1'b0, 1'b1);
            begin
                repeat (40) @(negedge clk);
                cfg_divider = 32'd50;
                cfg_par_en  = 1'b1;
            end
        join
        cfg_divider = 32'd16;
        cfg_par_en  = 1'b0;
        exp_q.push_back(8'hC3);
        check_eq("cfgchg flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
        pop_check("cfgchg");

        // ---------------- fill FIFO, overrun on fifth frame
        for (int i = 0; i < 5; i++) begin
            send_frame(9'(8'h11 * (i + 1)), 16, 1'b0, 1'b0, 1'b1);
            if (i < DEPTH) exp_q.push_back(8'(8'h11 * (i + 1)));
        end
        check_eq("full level", 32'(fifo_level), 32'd4);
        check_eq("overrun set", 32'(overrun), 32'd1);
        pulse_clr();
        check_eq("overrun clr", 32'(overrun), 32'd0);
        // push and pop in the same cycle while full
        fork
            send_frame(9'h066, 16, 1'b0, 1'b0, 1'b1);
            begin
                int n = 0;
                logic [DB-1:0] exp;
                while (!dut.r_push && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                exp = exp_q.pop_front();
                check_eq("fullpp head", 32'(rd_data), 32'(exp));
                rd_ready = 1'b1;
                @(negedge clk);
                rd_ready = 1'b0;
            end
        join
        exp_q.push_back(8'h66);
        check_eq("fullpp level", 32'(fifo_level), 32'd4);
        check_eq("fullpp no ovr", 32'(overrun), 32'd0);
        for (int i = 0; i < DEPTH; i++) pop_check("drain");
        check_eq("drain level", 32'(fifo_level), 32'd0);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        @(negedge clk);
        check_eq("pop empty level", 32'(fifo_level), 32'd0);
        pop_check("pop empty");

        // ---------------- parity
`ifdef UART_RX_PARITY_EN
        cfg_par_en  = 1'b1;
        cfg_par_odd = 1'b0;
        send_frame(9'h003, 16, 1'b1, 1'b1, 1'b1);
        check_eq("perr set", 32'(parity_err), 32'd1);
        check_eq("perr level", 32'(fifo_level), 32'd0);
        check_eq("perr no ferr", 32'(frame_err), 32'd0);
        pulse_clr();
        send_frame(9'h003, 16, 1'b1, 1'b0, 1'b1);
        exp_q.push_back(8'h03);
        check_eq("par ok flag", 32'(parity_err), 32'd0);
        pop_check("par even");
        cfg_par_odd = 1'b1;
        send_frame(9'h007, 16, 1'b1, 1'b0, 1'b1);
        exp_q.push_back(8'h07);
        pop_check("par odd");
        cfg_par_odd = 1'b0;
        send_frame(9'h003, 16, 1'b1, 1'b1, 1'b0);
        check_eq("both flags", {30'd0, frame_err, parity_err}, 32'd3);
        check_eq("both level", 32'(fifo_level), 32'd0);
        pulse_clr();
        cfg_par_en  = 1'b0;
`else
        cfg_par_en  = 1'b1;
        cfg_par_odd = 1'b1;
        send_frame(9'h003, 16, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(8'h03);
        check_eq("nopar perr", 32'(parity_err), 32'd0);
        check_eq("nopar ferr", 32'(frame_err), 32'd0);
        pop_check("nopar");
        cfg_par_en  = 1'b0;
        cfg_par_odd = 1'b0;
`endif

        // ---------------- reset in the middle of data bit 4
        cfg_divider = 32'd106;
        send_frame(9'h05A, 106, 1'b0, 1'b0, 1'b1);
        check_eq("prerst level", 32'(fifo_level), 32'd1);
        ser_rx = 1'b0;
        repeat (106) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] v;
            v = 8'hA5;
            ser_rx = v[i];
            repeat (106) @(negedge clk);
        end
        ser_rx = 1'b0;
        repeat (53) @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        check_eq("midrst valid", 32'(rd_valid), 32'd0);
        check_eq("midrst level", 32'(fifo_level), 32'd0);
        check_eq("midrst data", 32'(rd_data), 32'd0);
        check_eq("midrst flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
        resetn = 1'b1;
        repeat (53) @(negedge clk);
        ser_rx = 1'b1;
        repeat (400) @(negedge clk);
        check_eq("postrst level", 32'(fifo_level), 32'd0);
        check_eq("postrst state", 32'(dut.r_state), 32'(IDLE));
        send_frame(9'h0A5, 106, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(8'hA5);
        check_eq("A5 flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
        pop_check("A5");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_rx_fifo
`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter DIV_WIDTH, default 32, width of the bit-period divider.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port ser_rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port cfg_divider  input  DIV_WIDTH  clocks per bit.
REQ-008 SHALL have port cfg_parity_en  input  1  enable parity bit after data.
REQ-009 SHALL have port cfg_parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-010 SHALL have port rd_valid  output  1  FIFO not empty.
REQ-011 SHALL have port rd_ready  input  1  consumer pops when rd_valid and rd_ready are both high.
REQ-012 SHALL have port rd_data  output  DATA_BITS  FIFO head, LSB = first bit received.
REQ-013 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  occupied entries.
REQ-014 SHALL have ports frame_err, parity_err, overrun  output  1 each  sticky error flags.
REQ-015 SHALL have port err_clr  input  1  single-cycle pulse clearing all sticky flags.

Function
REQ-016 SHALL pass ser_rx through a 2-flop synchronizer (set to 1 on reset); all later logic uses the synchronized value.
REQ-017 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE: on synchronized low, SHALL latch the divider as max(cfg_divider,4), load half = latched/2, and enter START.
REQ-019 START: after half cycles, SHALL sample; if high (glitch), SHALL return to IDLE without pushing or flagging.
REQ-020 DATA: SHALL sample DATA_BITS bits, each one latched-divider period after the previous sample, shifting LSB first.
REQ-021 PARITY: SHALL be entered only when cfg_parity_en (sampled at start detection) is 1; SHALL sample one bit and compare it with the computed parity.
REQ-022 STOP: SHALL sample one period later, then return to IDLE. The stop-bit sample SHALL require the line to be high.
REQ-023 A frame with a low stop sample SHALL set frame_err and be discarded; a parity mismatch SHALL set parity_err and be discarded; if both occur, both flags SHALL be set.
REQ-024 A good frame SHALL be pushed into the FIFO on the cycle after the stop sample.
REQ-025 Changes to cfg_* during a frame SHALL NOT affect that frame.
REQ-026 A push when the FIFO is full and no pop occurs that cycle SHALL discard the new byte and set overrun.
REQ-027 A push and a pop in the same cycle when the FIFO is full SHALL both succeed, and fifo_level SHALL be unchanged.
REQ-028 A pop when the FIFO is empty SHALL be ignored. rd_data SHALL be undefined-but-stable when rd_valid is 0.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH. rd_valid and fifo_level SHALL be registered.
REQ-030 An err_clr pulse in the same cycle as a new error event SHALL leave that flag set.

Reset
REQ-031 On resetn low, all state SHALL clear immediately: FSM = IDLE, FIFO empty, rd_valid=0, fifo_level=0, rd_data=0, all flags 0.
REQ-032 A reset asserted mid-frame SHALL abort the frame. After release, the receiver SHALL wait for a fresh falling edge.

Configuration
REQ-033 The macro UART_RX_PARITY_EN SHALL compile in the PARITY state and parity logic.
REQ-034 Without UART_RX_PARITY_EN, cfg_parity_en and cfg_parity_odd SHALL remain as ports but be ignored, PARITY SHALL be unreachable, and parity_err SHALL be tied to 0.

Structure
REQ-035 Package uart_rx_pkg SHALL hold the FSM state encoding and MIN_DIVIDER=4.
REQ-036 The FIFO SHALL be the sub-module uart_rx_fifo_mem, parametrised by width and depth, with push/pop/full/empty/level.

Verification
REQ-037 divider=106, frame 0x41 at 8N1 -> rd_data=0x41, with rd_valid high no later than 1012 cycles after ser_rx falls; no flags set.
REQ-038 Low pulse of 40 cycles at divider=106 -> no push; FSM back in IDLE; no flags set.
REQ-039 Stop bit driven low on frame 0x55 -> FIFO level unchanged; frame_err=1; err_clr pulse -> frame_err=0.
REQ-040 FIFO_DEPTH=4, 5 frames sent with rd_ready=0 -> fifo_level=4, overrun=1, FIFO holds the first four bytes in order.
REQ-041 With the macro defined, cfg_parity_en=1 and cfg_parity_odd=0, frame 0x03 with parity bit 1 -> parity_err=1, no push; the same frame with parity bit 0 -> 0x03 pushed.
REQ-042 resetn asserted at data bit 4 of a frame -> all outputs 0; the next complete frame 0xA5 is received correctly.
